axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- Bridges a simple core-side request port to an AXI4 master port that drives the 32-bit SRAM slave wrapper through the bus.
- Converts one accepted request into one INCR burst: either an AR/R read burst or an AW/W/B write burst.
- Streams read data out to the core and write data in from the core, beat by beat.
- Reports completion and error status per transaction.

Parameters:
- MASTER_ID, 4'd0, value driven on ARID_M/AWID_M.
- ADDR_W, 32, address width (matches AXI_ADDR_BITS).
- DATA_W, 32, data width (matches AXI_DATA_BITS); AXI_STRB_BITS = DATA_W/8.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  1  core request valid
- req_ready  out  1  core request accepted when high with req_valid
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  32  byte start address; bits[1:0] ignored (forced 0)
- req_len  in  4  beats-1 (AXI_LEN_BITS)
- rd_valid  out  1  read beat valid to core
- rd_data  out  32  read beat data
- rd_last  out  1  final read beat
- rd_ready  in  1  core accepts read beat
- wr_valid  in  1  core write beat valid
- wr_data  in  32  write beat data
- wr_strb  in  4  write byte strobes
- wr_ready  out  1  write beat accepted
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done; 1 = non-OKAY response or RLAST mismatch
- ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M/ARVALID_M  out  4/32/4/3/2/1  AXI read address
- ARREADY_M  in  1
- RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M  in  4/32/2/1/1  AXI read data
- RREADY_M  out  1
- AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M/AWVALID_M  out  4/32/4/3/2/1  AXI write address
- AWREADY_M  in  1
- WDATA_M/WSTRB_M/WLAST_M/WVALID_M  out  32/4/1/1  AXI write data
- WREADY_M  in  1
- BID_M/BRESP_M/BVALID_M  in  4/2/1  AXI write response
- BREADY_M  out  1

Behaviour:
- States: IDLE, AR, R, AW, W, B. Reset (ARESET high at a clock edge) forces IDLE from any state, including mid-burst.
- Reset values: all VALID/READY outputs 0, done=0, err=0, beat counter 0, address and len registers 0. ARSIZE_M/AWSIZE_M are constant 3'b010; ARBURST_M/AWBURST_M are constant 2'b01 (INCR).
- req_ready = (state==IDLE). Acceptance happens on req_valid&req_ready at edge N.
  - Capture: {req_addr[31:2],2'b00}, req_len, req_write.
  - Next state: AW if req_write, else AR. ARVALID_M or AWVALID_M is high from cycle N+1.
- AR state: ARVALID_M=1. ARADDR_M and ARLEN_M are held stable until ARREADY_M. On handshake, go to R and clear the beat counter.
- R state: pass-through, no buffering.
  - rd_valid = RVALID_M, rd_data = RDATA_M, rd_last = RLAST_M, RREADY_M = rd_ready.
  - Each R handshake increments the counter (4-bit, no wrap in legal use).
  - err_acc is set if RRESP_M != 2'b00, if RLAST_M=1 with counter != len, or if RLAST_M=0 with counter == len.
  - Burst ends on R handshake with RLAST_M=1, or with counter==len if RLAST never arrives: go to IDLE, done=1 next cycle, err=err_acc.
- AW state: AWVALID_M=1, address and len held stable. WVALID_M stays 0 until AW completes, because the slave only raises WREADY after accepting AW. On handshake, go to W and clear the counter.
- W state:
  - WVALID_M = wr_valid, WDATA_M = wr_data, WSTRB_M = wr_strb, wr_ready = WREADY_M, WLAST_M = (counter==len).
  - Each W handshake increments the counter. The handshake with WLAST_M goes to B.
- B state: BREADY_M=1. On BVALID_M, go to IDLE; done=1 next cycle; err = (BRESP_M != 2'b00).
- done and err are registered, high for exactly one cycle. req_ready is already 1 in the cycle done is high, so back-to-back requests are allowed.
- Outside their owning state, rd_valid, wr_ready, RREADY_M, BREADY_M and WVALID_M are 0.
- RID_M/BID_M are ignored; single outstanding transaction only.
- len=0 is a single beat: WLAST_M is high on the first beat, and rd_last comes from the slave.

Test Plan:
- Reset mid-R-burst (len=3, after 2 beats) -> next cycle state IDLE, RREADY_M=0, ARVALID_M=0, done=0, req_ready=1.
- Read req addr=0x0000_0013, len=3; slave returns 0xA0..0xA3 with rd_ready=1 -> ARADDR_M=0x10, ARLEN_M=3, ARSIZE=2, ARBURST=1. rd_data is 0xA0,0xA1,0xA2,0xA3 with rd_last on beat 4. done=1, err=0 one cycle after the last beat.
- Read with rd_ready toggling 1,0,1,0 -> RREADY_M mirrors rd_ready; the beat count still reaches 4; no beat is lost or duplicated.
- Write addr=0x40, len=1, wr_strb=4'b0011, data 0x11111111/0x22222222 -> AWVALID_M precedes WVALID_M, WLAST_M is on beat 2 only, WSTRB_M=4'b0011. After BVALID with OKAY: done=1, err=0.
- Write with ARREADY-style stall (AWREADY_M held 0 for 5 cycles) -> AWADDR_M/AWLEN_M stable throughout, wr_ready=0, then normal completion.
- Slave returns RLAST on beat 2 of len=3, or BRESP=2'b10 -> done=1, err=1, state returns to IDLE.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// Core-side request/stream port and AXI4 master port of axi_burst_master.
// Signal names match the original flat port list so that hookup stays 1:1.
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // core request
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  // core read stream
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;
  // core write stream
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_ready;
  // status
  logic              done;
  logic              err;
  // AXI read address
  logic [3:0]        ARID_M;
  logic [ADDR_W-1:0] ARADDR_M;
  logic [3:0]        ARLEN_M;
  logic [2:0]        ARSIZE_M;
  logic [1:0]        ARBURST_M;
  logic              ARVALID_M;
  logic              ARREADY_M;
  // AXI read data
  logic [3:0]        RID_M;
  logic [DATA_W-1:0] RDATA_M;
  logic [1:0]        RRESP_M;
  logic              RLAST_M;
  logic              RVALID_M;
  logic              RREADY_M;
  // AXI write address
  logic [3:0]        AWID_M;
  logic [ADDR_W-1:0] AWADDR_M;
  logic [3:0]        AWLEN_M;
  logic [2:0]        AWSIZE_M;
  logic [1:0]        AWBURST_M;
  logic              AWVALID_M;
  logic              AWREADY_M;
  // AXI write data
  logic [DATA_W-1:0] WDATA_M;
  logic [STRB_W-1:0] WSTRB_M;
  logic              WLAST_M;
  logic              WVALID_M;
  logic              WREADY_M;
  // AXI write response
  logic [3:0]        BID_M;
  logic [1:0]        BRESP_M;
  logic              BVALID_M;
  logic              BREADY_M;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    output req_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    input  wr_valid, wr_data, wr_strb,
    output wr_ready,
    output done, err,
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M,
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    input  req_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    output wr_valid, wr_data, wr_strb,
    input  wr_ready,
    input  done, err,
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M,
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M
  );
endinterface

// File: rtl/axi_burst_master.sv
// Turns one core request into one AXI4 INCR burst (read AR/R or write AW/W/B),
// streaming beats straight through and reporting done/err per transaction.
module axi_burst_master #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input logic               ACLK,
  input logic               ARESET,
  axi_burst_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_acc_q, err_acc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept;
  logic r_hs;
  logic w_hs;
  logic last_cnt;
  logic beat_err;

  // IDs are not checked (single outstanding); address LSBs are forced to 0
  logic unused_inputs;
  assign unused_inputs = ^{bus.RID_M, bus.BID_M, bus.req_addr[1:0]};

  assign last_cnt = (cnt_q == len_q);
  assign accept   = bus.req_valid && (state_q == S_IDLE);
  assign r_hs     = (state_q == S_R) && bus.RVALID_M && bus.rd_ready;
  assign w_hs     = (state_q == S_W) && bus.wr_valid && bus.WREADY_M;
  assign beat_err = (bus.RRESP_M != 2'b00) ||
                    (bus.RLAST_M && !last_cnt) ||
                    (!bus.RLAST_M && last_cnt);

  // Core-side handshakes and pass-through beat paths, gated by owning state
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rd_valid  = (state_q == S_R) && bus.RVALID_M;
  assign bus.rd_data   = bus.RDATA_M;
  assign bus.rd_last   = (state_q == S_R) && bus.RLAST_M;
  assign bus.RREADY_M  = (state_q == S_R) && bus.rd_ready;
  assign bus.wr_ready  = (state_q == S_W) && bus.WREADY_M;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // AXI address channels: address/len come straight from the capture registers
  assign bus.ARID_M    = MASTER_ID;
  assign bus.ARADDR_M  = addr_q;
  assign bus.ARLEN_M   = len_q;
  assign bus.ARSIZE_M  = 3'b010;
  assign bus.ARBURST_M = 2'b01;
  assign bus.ARVALID_M = (state_q == S_AR);
  assign bus.AWID_M    = MASTER_ID;
  assign bus.AWADDR_M  = addr_q;
  assign bus.AWLEN_M   = len_q;
  assign bus.AWSIZE_M  = 3'b010;
  assign bus.AWBURST_M = 2'b01;
  assign bus.AWVALID_M = (state_q == S_AW);

  // AXI write data / response
  assign bus.WDATA_M   = bus.wr_data;
  assign bus.WSTRB_M   = bus.wr_strb;
  assign bus.WLAST_M   = (state_q == S_W) && last_cnt;
  assign bus.WVALID_M  = (state_q == S_W) && bus.wr_valid;
  assign bus.BREADY_M  = (state_q == S_B);

  // Next-state, counter, error accumulation and completion pulse
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = {bus.req_addr[ADDR_W-1:2], 2'b00};
          len_d     = bus.req_len;
          err_acc_d = 1'b0;
          state_d   = bus.req_write ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (bus.ARREADY_M) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (r_hs) begin
          cnt_d     = cnt_q + 4'd1;
          err_acc_d = err_acc_q || beat_err;
          // a missing RLAST still terminates the burst at the expected count
          if (bus.RLAST_M || last_cnt) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = err_acc_q || beat_err;
          end
        end
      end
      S_AW: begin
        if (bus.AWREADY_M) begin
          cnt_d   = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          cnt_d = cnt_q + 4'd1;
          if (last_cnt) state_d = S_B;
        end
      end
      S_B: begin
        if (bus.BVALID_M) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = (bus.BRESP_M != 2'b00);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a table of read/write transactions
// with hand-computed expectations, plus reset-mid-burst handled separately.
module tb_axi_burst_master;

  logic ACLK;
  logic ARESET;

  axi_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_burst_master #(.MASTER_ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic [3:0]  len;
    int unsigned last_beat;   // read: beat index on which slave asserts RLAST
    logic [1:0]  resp;        // RRESP for all beats / BRESP
    bit          toggle;      // read: rd_ready 1,0,1,0...
    int unsigned stall;       // write: cycles AWREADY_M held low
    logic [3:0]  strb;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.rd_ready  = 1'b0; bus.wr_valid  = 1'b0; bus.wr_data  = '0; bus.wr_strb = '0;
    bus.ARREADY_M = 1'b0; bus.RID_M = '0; bus.RDATA_M = '0; bus.RRESP_M = '0;
    bus.RLAST_M   = 1'b0; bus.RVALID_M = 1'b0; bus.AWREADY_M = 1'b0; bus.WREADY_M = 1'b0;
    bus.BID_M = '0; bus.BRESP_M = '0; bus.BVALID_M = 1'b0;
  endtask

  task automatic finish_txn(input string tag, input logic exp_err);
    check({tag, " done"}, bus.done, 1'b1);
    check({tag, " err"}, bus.err, exp_err);
    check({tag, " req_ready at done"}, bus.req_ready, 1'b1);
    tick();
    check({tag, " done pulse width"}, bus.done, 1'b0);
  endtask

  task automatic run_read(input string tag, input vec_t v);
    int unsigned beat = 0;
    int unsigned cyc  = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = v.addr; bus.req_len = v.len;
    check({tag, " req_ready idle"}, bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    check({tag, " ARVALID"}, bus.ARVALID_M, 1'b1);
    check({tag, " ARADDR"}, bus.ARADDR_M, v.exp_addr);
    check({tag, " ARLEN"}, bus.ARLEN_M, v.len);
    check({tag, " ARSIZE"}, bus.ARSIZE_M, 3'b010);
    check({tag, " ARBURST"}, bus.ARBURST_M, 2'b01);
    check({tag, " req_ready busy"}, bus.req_ready, 1'b0);
    bus.ARREADY_M = 1'b1;
    tick();
    bus.ARREADY_M = 1'b0;
    check({tag, " ARVALID dropped"}, bus.ARVALID_M, 1'b0);
    while (beat <= v.last_beat && cyc < 64) begin
      bus.RVALID_M = 1'b1;
      bus.RDATA_M  = 32'hA0 + beat;
      bus.RLAST_M  = (beat == v.last_beat);
      bus.RRESP_M  = v.resp;
      bus.rd_ready = v.toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      check({tag, " RREADY mirrors rd_ready"}, bus.RREADY_M, bus.rd_ready);
      check({tag, " rd_valid"}, bus.rd_valid, 1'b1);
      if (bus.rd_ready) begin
        check({tag, " rd_data"}, bus.rd_data, 32'hA0 + beat);
        check({tag, " rd_last"}, bus.rd_last, (beat == v.last_beat));
      end
      tick();
      if (bus.rd_ready) beat++;
      cyc++;
    end
    bus.RVALID_M = 1'b0; bus.RLAST_M = 1'b0; bus.rd_ready = 1'b0; bus.RRESP_M = '0;
    check({tag, " beat budget"}, cyc < 64, 1'b1);
    finish_txn(tag, v.exp_err);
  endtask

  task automatic run_write(input string tag, input vec_t v);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = v.addr; bus.req_len = v.len;
    tick();
    bus.req_valid = 1'b0; bus.req_addr = 32'hDEAD_BEEF; bus.req_len = 4'hF;
    // core and slave already willing: W must still wait for AW
    bus.wr_valid = 1'b1; bus.wr_data = 32'h1111_1111; bus.wr_strb = v.strb;
    bus.WREADY_M = 1'b1;
    #1;
    for (int unsigned s = 0; s <= v.stall; s++) begin
      check({tag, " AWVALID"}, bus.AWVALID_M, 1'b1);
      check({tag, " AWADDR stable"}, bus.AWADDR_M, v.exp_addr);
      check({tag, " AWLEN stable"}, bus.AWLEN_M, v.len);
      check({tag, " WVALID held off"}, bus.WVALID_M, 1'b0);
      check({tag, " wr_ready held off"}, bus.wr_ready, 1'b0);
      if (s == v.stall) bus.AWREADY_M = 1'b1;
      tick();
    end
    bus.AWREADY_M = 1'b0;
    check({tag, " AWSIZE"}, bus.AWSIZE_M, 3'b010);
    check({tag, " AWBURST"}, bus.AWBURST_M, 2'b01);
    for (int unsigned b = 0; b <= v.len; b++) begin
      bus.wr_data = 32'h1111_1111 * (b + 1);
      #1;
      check({tag, " AWVALID low in W"}, bus.AWVALID_M, 1'b0);
      check({tag, " WVALID"}, bus.WVALID_M, 1'b1);
      check({tag, " WDATA"}, bus.WDATA_M, 32'h1111_1111 * (b + 1));
      check({tag, " WSTRB"}, bus.WSTRB_M, v.strb);
      check({tag, " WLAST"}, bus.WLAST_M, (b == v.len));
      check({tag, " wr_ready"}, bus.wr_ready, 1'b1);
      tick();
    end
    bus.wr_valid = 1'b0; bus.WREADY_M = 1'b0;
    check({tag, " BREADY"}, bus.BREADY_M, 1'b1);
    check({tag, " WVALID low in B"}, bus.WVALID_M, 1'b0);
    tick();
    check({tag, " BREADY waits"}, bus.BREADY_M, 1'b1);
    check({tag, " no early done"}, bus.done, 1'b0);
    bus.BVALID_M = 1'b1; bus.BRESP_M = v.resp;
    tick();
    bus.BVALID_M = 1'b0; bus.BRESP_M = '0;
    finish_txn(tag, v.exp_err);
  endtask

  initial begin
    //         wr   addr          exp_addr      len  lastb resp   tgl stall strb     exp_err
    vecs[0] = '{1'b0, 32'h0000_0013, 32'h0000_0010, 4'd3, 3, 2'b00, 1'b0, 0, 4'b0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0102, 32'h0000_0100, 4'd0, 0, 2'b00, 1'b0, 0, 4'b0000, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0040, 32'h0000_0040, 4'd1, 0, 2'b00, 1'b0, 0, 4'b0011, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0083, 32'h0000_0080, 4'd2, 0, 2'b00, 1'b0, 5, 4'b1111, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0020, 32'h0000_0020, 4'd3, 1, 2'b00, 1'b0, 0, 4'b0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0044, 32'h0000_0044, 4'd0, 0, 2'b10, 1'b0, 0, 4'b1000, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0030, 32'h0000_0030, 4'd1, 1, 2'b10, 1'b0, 0, 4'b0000, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_0201, 32'h0000_0200, 4'd3, 3, 2'b00, 1'b1, 0, 4'b0000, 1'b0};

    idle_inputs();
    ARESET = 1'b1;
    tick();
    tick();
    check("reset req_ready", bus.req_ready, 1'b1);
    check("reset ARVALID", bus.ARVALID_M, 1'b0);
    check("reset AWVALID", bus.AWVALID_M, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset err", bus.err, 1'b0);
    check("reset ARADDR", bus.ARADDR_M, 32'h0);
    ARESET = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (vecs[i].is_write) run_write(tag, vecs[i]);
      else                  run_read(tag, vecs[i]);
    end

    // reset in the middle of a len=3 read after two beats
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h60; bus.req_len = 4'd3;
    tick();
    bus.req_valid = 1'b0;
    bus.ARREADY_M = 1'b1;
    tick();
    bus.ARREADY_M = 1'b0;
    bus.RVALID_M = 1'b1; bus.rd_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bus.RDATA_M = 32'hB0 + b;
      tick();
    end
    check("midR RREADY before reset", bus.RREADY_M, 1'b1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    #1;
    check("midR RREADY after reset", bus.RREADY_M, 1'b0);
    check("midR rd_valid after reset", bus.rd_valid, 1'b0);
    check("midR ARVALID after reset", bus.ARVALID_M, 1'b0);
    check("midR done after reset", bus.done, 1'b0);
    check("midR req_ready after reset", bus.req_ready, 1'b1);
    idle_inputs();
    tick();

    // a fresh read right after the aborted one still behaves
    run_read("post-reset", vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
